// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
//   Shares one whole-word SRAM driver between the instruction-fetch (IF)
//   port and the data-memory (MEM) port. MEM wins ties. Sub-word stores are
//   turned into an atomic read-modify-write. Each finished request gets a
//   one-cycle ready pulse on its own port.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-low reset
//   if_req/if_addr           fetch request, byte address
//   if_rdata/if_ready        fetched word (registered), completion pulse
//   mem_req/mem_we/mem_sel   data request, store flag, byte enables
//   mem_addr/mem_wdata       data byte address, store data
//   mem_rdata/mem_ready      load word (registered), completion pulse
//   ram_en/ram_re/ram_we     driver strobes, decoded from state
//   ram_addr/ram_wdata       driver word address / write data
//   ram_rdata/ram_ack        driver read data / write acknowledge
module sram_bus_arbiter #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [31:0]         if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [DATA_W/8-1:0] mem_sel,
    input  logic [31:0]         mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_ready,
    output logic                ram_en,
    output logic                ram_re,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata,
    input  logic                ram_ack
);

    localparam int NB = DATA_W / 8;
    localparam logic [NB-1:0] SEL_ALL = '1;

    localparam logic [2:0] S_BOOT   = 3'd0;
    localparam logic [2:0] S_IDLE   = 3'd1;
    localparam logic [2:0] S_RISSUE = 3'd2;
    localparam logic [2:0] S_RDATA  = 3'd3;
    localparam logic [2:0] S_WISSUE = 3'd4;
    localparam logic [2:0] S_WWAIT  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]        state_q, state_d;
    logic              port_q, port_d;      // 0 = IF, 1 = MEM
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [NB-1:0]     sel_q, sel_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] merge_q, merge_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

    // Byte-offset bits and address bits above the SRAM window are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                mem_addr[31:ADDR_W+2], mem_addr[1:0]};

    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        addr_d      = addr_q;
        we_d        = we_q;
        sel_d       = sel_q;
        wdata_d     = wdata_q;
        merge_d     = merge_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        case (state_q)
            // One quiet cycle so a write the driver started before reset can drain.
            S_BOOT: state_d = S_IDLE;
            S_IDLE: begin
                if (mem_req) begin
                    port_d  = 1'b1;
                    addr_d  = mem_addr[ADDR_W+1:2];
                    we_d    = mem_we;
                    sel_d   = mem_sel;
                    wdata_d = mem_wdata;
                    if (!mem_we) begin
                        state_d = S_RISSUE;
                    end else if (mem_sel == SEL_ALL) begin
                        merge_d = mem_wdata;
                        state_d = S_WISSUE;
                    end else if (mem_sel == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RISSUE;     // partial store: read first
                    end
                end else if (if_req) begin
                    port_d  = 1'b0;
                    addr_d  = if_addr[ADDR_W+1:2];
                    we_d    = 1'b0;
                    sel_d   = '0;
                    wdata_d = '0;
                    state_d = S_RISSUE;
                end
            end
            S_RISSUE: state_d = S_RDATA;
            S_RDATA: begin
                if (we_q) begin
                    // RMW: splice the enabled store bytes into the word just read.
                    for (int i = 0; i < NB; i++)
                        merge_d[8*i +: 8] = sel_q[i] ? wdata_q[8*i +: 8] : ram_rdata[8*i +: 8];
                    state_d = S_WISSUE;
                end else begin
                    if (port_q) mem_rdata_d = ram_rdata;
                    else        if_rdata_d  = ram_rdata;
                    state_d = S_DONE;
                end
            end
            S_WISSUE: state_d = S_WWAIT;
            S_WWAIT:  if (ram_ack) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_BOOT;
            port_q      <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            wdata_q     <= '0;
            merge_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            wdata_q     <= wdata_d;
            merge_q     <= merge_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign ram_re    = (state_q == S_RISSUE) || (state_q == S_RDATA);
    assign ram_we    = (state_q == S_WISSUE);
    assign ram_en    = ram_re || ram_we;
    assign ram_addr  = addr_q;
    assign ram_wdata = merge_q;

    assign if_ready  = (state_q == S_DONE) && !port_q;
    assign mem_ready = (state_q == S_DONE) &&  port_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter with a small SRAM driver model:
// combinational read data, write on the W_ISSUE edge, ack low for the one
// cycle after a write issue (or held low on demand).
module tb_sram_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        ram_en, ram_re, ram_we;
    logic [20:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ack;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.ADDR_W(21), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .ram_en(ram_en), .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack)
    );

    // SRAM model: 16 words, index = {base/ext bit, word[2:0]}.
    logic [31:0] sram [0:15];
    logic        hold_ack;
    logic        pl_we;
    logic [3:0]  pl_idx;
    logic [31:0] pl_data;
    logic [3:0]  idx;
    assign idx       = {ram_addr[20], ram_addr[2:0]};
    assign ram_rdata = ram_re ? sram[idx] : 32'h0;

    always @(posedge clk) begin
        ram_ack <= hold_ack ? 1'b0 : !ram_we;
        if (ram_we) sram[idx] <= ram_wdata;
        else if (pl_we) sram[pl_idx] <= pl_data;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [3:0] i, input logic [31:0] d);
        pl_we = 1'b1; pl_idx = i; pl_data = d;
        tick();
        pl_we = 1'b0;
    endtask

    // Caller has set requests during cycle 0 (an IDLE cycle). Runs ncyc
    // cycles, dropping each port's request when its ready pulse is seen.
    task automatic xact(input int ncyc,
                        output int m_cyc, output int i_cyc, output int m_cnt, output int i_cnt,
                        output int en_cnt, output int we_cnt,
                        output logic [31:0] wd, output logic [31:0] wa, output logic [31:0] ra);
        m_cyc = -1; i_cyc = -1; m_cnt = 0; i_cnt = 0; en_cnt = 0; we_cnt = 0;
        wd = 'x; wa = 'x; ra = 'x;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            if (ram_en) begin
                if (en_cnt == 0) ra = 32'(ram_addr);
                en_cnt++;
            end
            if (ram_we) begin
                we_cnt++; wd = ram_wdata; wa = 32'(ram_addr);
            end
            if (mem_ready) begin
                if (m_cnt == 0) m_cyc = c;
                m_cnt++; mem_req = 1'b0;
            end
            if (if_ready) begin
                if (i_cnt == 0) i_cyc = c;
                i_cnt++; if_req = 1'b0;
            end
        end
    endtask

    int mc, ic, mn, inn, en, wen;
    logic [31:0] wd, wa, ra;

    initial begin
        rst = 1'b0; hold_ack = 1'b0; pl_we = 1'b0; pl_idx = '0; pl_data = '0;
        if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;

        // Preload during reset.
        preload(4'd4, 32'h1234_5678);
        preload(4'd6, 32'hAABB_CCDD);
        preload(4'd1, 32'h1111_1111);
        preload(4'd2, 32'h2222_2222);
        preload(4'd8, 32'h0);
        tick();

        chk("rst_if_ready",  {31'b0, if_ready},  32'h0);
        chk("rst_mem_ready", {31'b0, mem_ready}, 32'h0);
        chk("rst_ram_en",    {29'b0, ram_en, ram_re, ram_we}, 32'h0);
        chk("rst_ram_addr",  32'(ram_addr), 32'h0);
        chk("rst_ram_wdata", ram_wdata, 32'h0);
        chk("rst_if_rdata",  if_rdata,  32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);

        // IF read straight out of reset: BOOT, then IDLE samples the request.
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h0000_0010;
        chk("boot_no_en", {31'b0, ram_en}, 32'h0);
        tick();
        chk("idle_no_en", {31'b0, ram_en}, 32'h0);
        xact(6, mc, ic, mn, inn, en, wen, wd, wa, ra);
        chk("if_rdy_cyc",  32'(ic),  32'd3);
        chk("if_rdy_cnt",  32'(inn), 32'd1);
        chk("if_en_cnt",   32'(en),  32'd2);
        chk("if_ram_addr", ra, 32'h4);
        chk("if_rdata",    if_rdata, 32'h1234_5678);
        chk("if_no_mem",   32'(mn),  32'd0);

        // Full-word store to ext SRAM.
        mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'hF;
        mem_addr = 32'h0040_0000; mem_wdata = 32'hDEAD_BEEF;
        xact(7, mc, ic, mn, inn, en, wen, wd, wa, ra);
        chk("st_rdy_cyc", 32'(mc),  32'd4);
        chk("st_rdy_cnt", 32'(mn),  32'd1);
        chk("st_we_cnt",  32'(wen), 32'd1);
        chk("st_addr",    wa, 32'h0010_0000);
        chk("st_wdata",   wd, 32'hDEAD_BEEF);
        chk("st_sram",    sram[8], 32'hDEAD_BEEF);
        chk("st_mem_rdata_kept", mem_rdata, 32'h0);

        // Partial store: read-modify-write of byte 1.
        mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b0010;
        mem_addr = 32'h0000_0018; mem_wdata = 32'h0000_5500;
        xact(9, mc, ic, mn, inn, en, wen, wd, wa, ra);
        chk("rmw_rdy_cyc", 32'(mc),  32'd6);
        chk("rmw_we_cnt",  32'(wen), 32'd1);
        chk("rmw_en_cnt",  32'(en),  32'd3);
        chk("rmw_wdata",   wd, 32'hAABB_55DD);
        chk("rmw_sram",    sram[6], 32'hAABB_55DD);

        // Simultaneous requests: MEM load first, then IF.
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h0000_0008;
        if_req = 1'b1; if_addr = 32'h0000_0004;
        xact(10, mc, ic, mn, inn, en, wen, wd, wa, ra);
        chk("both_mem_cyc",   32'(mc), 32'd3);
        chk("both_if_cyc",    32'(ic), 32'd7);
        chk("both_first_addr", ra, 32'h2);
        chk("both_mem_rdata", mem_rdata, 32'h2222_2222);
        chk("both_if_rdata",  if_rdata,  32'h1111_1111);

        // sel==0 store is a no-op that still completes.
        mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'h0;
        mem_addr = 32'h0000_0018; mem_wdata = 32'hFFFF_FFFF;
        xact(4, mc, ic, mn, inn, en, wen, wd, wa, ra);
        chk("nop_rdy_cyc", 32'(mc), 32'd1);
        chk("nop_en_cnt",  32'(en), 32'd0);
        chk("nop_sram",    sram[6], 32'hAABB_55DD);
        chk("nop_mem_rdata", mem_rdata, 32'h2222_2222);

        // Reset while stalled in W_WAIT.
        hold_ack = 1'b1;
        mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'hF;
        mem_addr = 32'h0000_0000; mem_wdata = 32'hCAFE_F00D;
        mn = 0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (mem_ready) mn++;
        end
        mem_req = 1'b0; rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            if (mem_ready || if_ready) mn++;
        end
        chk("rstw_no_ready", 32'(mn), 32'd0);
        chk("rstw_ram",  {29'b0, ram_en, ram_re, ram_we}, 32'h0);
        chk("rstw_addr", 32'(ram_addr), 32'h0);
        chk("rstw_wdata", ram_wdata, 32'h0);
        chk("rstw_mem_rdata", mem_rdata, 32'h0);
        chk("rstw_if_rdata",  if_rdata,  32'h0);

        rst = 1'b1; hold_ack = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0010;
        chk("rstw_boot_no_en", {31'b0, ram_en}, 32'h0);
        tick();
        xact(6, mc, ic, mn, inn, en, wen, wd, wa, ra);
        chk("rstw_if_cyc",   32'(ic),  32'd3);
        chk("rstw_if_cnt",   32'(inn), 32'd1);
        chk("rstw_if_rdata", if_rdata, 32'h1234_5678);
        chk("rstw_no_mem",   32'(mn),  32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
